// File: rtl/spi_rx_fifo.sv
// SPI slave receiver: oversamples an asynchronous SPI master with clk, assembles
// MSB-first words and queues them in a first-word-fall-through FIFO.
module spi_rx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    input  logic                     done_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     frame_err_o,
    output logic                     overflow_o
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(DATA_W + 1);

    localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_W);
    localparam logic [CW-1:0]   FIRST_BIT = CW'(1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    logic sclk_meta_q, sclk_sync_q, sclk_dly_q;
    logic mosi_meta_q, mosi_sync_q;
    logic done_meta_q, done_sync_q, done_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_dly_q  <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            done_dly_q  <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_dly_q  <= sclk_sync_q;
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
            done_meta_q <= done_i;
            done_sync_q <= done_meta_q;
            done_dly_q  <= done_sync_q;
        end
    end

    logic sclk_rise;
    logic done_rise;

    assign sclk_rise = sclk_sync_q & ~sclk_dly_q;
    assign done_rise = done_sync_q & ~done_dly_q;

    state_t              state_q, state_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                push_q, push_d;
    logic [DATA_W-1:0]   push_data_q, push_data_d;
    logic                frame_err_q, frame_err_d;

    // COMMIT hands the word to a registered push strobe and, if an sclk edge
    // lands in the same cycle, starts the next word with that bit.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sclk_rise) begin
                    shift_d   = {{(DATA_W-1){1'b0}}, mosi_sync_q};
                    bit_cnt_d = FIRST_BIT;
                    state_d   = (FIRST_BIT == LAST_BIT) ? COMMIT : SHIFT;
                end
            end
            SHIFT: begin
                if (done_rise) begin
                    shift_d     = '0;
                    bit_cnt_d   = '0;
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    shift_d   = {shift_q[DATA_W-2:0], mosi_sync_q};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_d == LAST_BIT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                push_d      = 1'b1;
                push_data_d = shift_q;
                if (sclk_rise) begin
                    shift_d   = {{(DATA_W-1){1'b0}}, mosi_sync_q};
                    bit_cnt_d = FIRST_BIT;
                    state_d   = (FIRST_BIT == LAST_BIT) ? COMMIT : SHIFT;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                shift_d   = '0;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              fifo_empty, fifo_full;
    logic              do_pop, do_write;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // A push into a full FIFO still lands when the same cycle pops the head.
    always_comb begin
        do_pop     = rd_en_i & ~fifo_empty;
        do_write   = push_q & (~fifo_full | do_pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_q & fifo_full & ~do_pop);
        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_write, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    assign rd_data_o   = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign empty_o     = fifo_empty;
    assign full_o      = fifo_full;
    assign count_o     = count_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

    a_not_full_and_empty : assert property (@(posedge clk) disable iff (rst)
        !(fifo_full && fifo_empty));
    a_count_in_range : assert property (@(posedge clk) disable iff (rst)
        count_q <= FULL_CNT);

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Scoreboard bench for spi_rx_fifo: drives SPI frames at clk/8 and checks
// popped words, flags and counters against a queue-based model.
module tb_spi_rx_fifo;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int HALF   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sclk_i;
    logic              mosi_i;
    logic              done_i;
    logic              rd_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              empty_o;
    logic              full_o;
    logic [3:0]        count_o;
    logic              frame_err_o;
    logic              overflow_o;

    int          checks = 0;
    int          failures = 0;
    int          err_cycles = 0;
    int          model_count = 0;
    logic        exp_overflow = 1'b0;
    logic [15:0] sb_q [$];

    spi_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (sclk_i),
        .mosi_i      (mosi_i),
        .done_i      (done_i),
        .rd_en_i     (rd_en_i),
        .rd_data_o   (rd_data_o),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err_o === 1'b1) err_cycles++;
    end

    task automatic send_bit(input logic b);
        mosi_i = b;
        sclk_i = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_i = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
        if (model_count < DEPTH) begin
            sb_q.push_back(w);
            model_count++;
        end else begin
            exp_overflow = 1'b1;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pop_word(input string name);
        logic [15:0] exp;
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $display("[TB] FAIL %s scoreboard_empty got=%0d required=1", name, sb_q.size());
            return;
        end
        exp = sb_q.pop_front();
        checks++;
        if (rd_data_o !== exp) begin
            failures++;
            $display("[TB] FAIL %s data got=%h required=%h", name, rd_data_o, exp);
        end
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        model_count--;
        checks++;
        if (count_o !== 4'(model_count)) begin
            failures++;
            $display("[TB] FAIL %s count got=%0d required=%0d", name, count_o, model_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; done_i = 1'b0; rd_en_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (count_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d required=0", count_o); end
        checks++;
        if (empty_o !== 1'b1 || full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_flags got=%b%b required=10", empty_o, full_o);
        end
        checks++;
        if (rd_data_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_data got=%h required=0000", rd_data_o); end
        checks++;
        if (frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_err got=%b%b required=00", frame_err_o, overflow_o);
        end
        rst = 1'b0;
        sb_q.delete(); model_count = 0; exp_overflow = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        int e0 = err_cycles;
        int waited = 0;
        send_word(16'hA5C3);
        while (empty_o !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 20) begin failures++; $display("[TB] FAIL s1_timeout got=%0d required<20", waited); end
        done_i = 1'b1;
        repeat (4) @(negedge clk);
        done_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rd_data_o !== 16'hA5C3) begin failures++; $display("[TB] FAIL s1_data got=%h required=a5c3", rd_data_o); end
        checks++;
        if (count_o !== 4'd1 || empty_o !== 1'b0) begin
            failures++; $display("[TB] FAIL s1_count got=%0d/%b required=1/0", count_o, empty_o);
        end
        checks++;
        if (err_cycles != e0) begin failures++; $display("[TB] FAIL s1_no_frame_err got=%0d required=0", err_cycles - e0); end
        pop_word("s1_pop");
    endtask

    task automatic test_frame_err();
        int e0 = err_cycles;
        int c0 = model_count;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        done_i = 1'b1;
        repeat (6) @(negedge clk);
        done_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cycles - e0 != 1) begin failures++; $display("[TB] FAIL s3_pulse_len got=%0d required=1", err_cycles - e0); end
        checks++;
        if (count_o !== 4'(c0)) begin failures++; $display("[TB] FAIL s3_count got=%0d required=%0d", count_o, c0); end
        send_word(16'h1234);
        pop_word("s3_next_word");
    endtask

    task automatic test_overflow();
        logic [15:0] w;
        for (int i = 1; i <= 8; i++) begin
            w = 16'(i);
            send_word(w);
        end
        checks++;
        if (full_o !== 1'b1) begin failures++; $display("[TB] FAIL s2_full got=%b required=1", full_o); end
        send_word(16'h0009);
        checks++;
        if (overflow_o !== exp_overflow) begin failures++; $display("[TB] FAIL s2_overflow got=%b required=%b", overflow_o, exp_overflow); end
        checks++;
        if (count_o !== 4'd8) begin failures++; $display("[TB] FAIL s2_count got=%0d required=8", count_o); end
        for (int i = 0; i < 8; i++) pop_word("s2_pop");
        checks++;
        if (empty_o !== 1'b1) begin failures++; $display("[TB] FAIL s2_empty got=%b required=1", empty_o); end
    endtask

    task automatic test_reset_midframe();
        int e0;
        logic [15:0] w = 16'hFFFF;
        send_word(16'h5A5A);
        for (int i = 0; i < 10; i++) send_bit(w[DATA_W-1-i]);
        e0 = err_cycles;
        rst = 1'b1; sclk_i = 1'b0;
        @(negedge clk);
        checks++;
        if (count_o !== 4'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            failures++; $display("[TB] FAIL s5_fifo_state got=%0d/%b/%b required=0/1/0", count_o, empty_o, full_o);
        end
        checks++;
        if (rd_data_o !== 16'h0 || overflow_o !== 1'b0) begin
            failures++; $display("[TB] FAIL s5_data_ovf got=%h/%b required=0000/0", rd_data_o, overflow_o);
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete(); model_count = 0; exp_overflow = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (err_cycles != e0) begin failures++; $display("[TB] FAIL s5_no_frame_err got=%0d required=0", err_cycles - e0); end
        send_word(16'h00FF);
        pop_word("s5_next_word");
    endtask

    task automatic test_full_pop();
        logic [15:0] w = 16'hBEEF;
        for (int i = 0; i < 8; i++) send_word(16'h0100 + 16'(i));
        checks++;
        if (full_o !== 1'b1) begin failures++; $display("[TB] FAIL s4_full got=%b required=1", full_o); end
        for (int i = DATA_W - 1; i >= 1; i--) send_bit(w[i]);
        mosi_i = w[0];
        sclk_i = 1'b0;
        repeat (HALF) @(negedge clk);
        sclk_i = 1'b1;
        repeat (HALF) @(negedge clk);
        checks++;
        if (rd_data_o !== sb_q[0]) begin failures++; $display("[TB] FAIL s4_head got=%h required=%h", rd_data_o, sb_q[0]); end
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
        void'(sb_q.pop_front());
        sb_q.push_back(w);
        repeat (3) @(negedge clk);
        checks++;
        if (count_o !== 4'd8) begin failures++; $display("[TB] FAIL s4_count got=%0d required=8", count_o); end
        checks++;
        if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL s4_overflow got=%b required=0", overflow_o); end
        for (int i = 0; i < 8; i++) pop_word("s4_pop");
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) send_word(16'hC000 + 16'(r * 16 + i));
            checks++;
            if (full_o !== 1'b1) begin failures++; $display("[TB] FAIL s6_full_%0d got=%b required=1", r, full_o); end
            for (int i = 0; i < 8; i++) pop_word("s6_pop");
            rd_en_i = 1'b1;
            repeat (2) @(negedge clk);
            rd_en_i = 1'b0;
            @(negedge clk);
            checks++;
            if (count_o !== 4'd0 || empty_o !== 1'b1) begin
                failures++; $display("[TB] FAIL s6_empty_pop_%0d got=%0d/%b required=0/1", r, count_o, empty_o);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sclk_i = 1'b0; mosi_i = 1'b0; done_i = 1'b0; rd_en_i = 1'b0;
        @(negedge clk);
        $display("[TB] starting spi_rx_fifo bench");
        test_reset();
        test_single_word();
        test_frame_err();
        test_overflow();
        test_reset_midframe();
        test_full_pop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_rx_fifo.md
SPI_RX_FIFO -- requirements
Module: spi_rx_fifo

Interface
REQ-001 Parameter DATA_W, default 16, SPI word width in bits (range 4..32).
REQ-002 Parameter DEPTH, default 8, FIFO depth in words (power of two, range 2..64).
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 sclk_i  input  1  serial clock from the upstream SPI master; asynchronous to clk.
REQ-006 mosi_i  input  1  serial data, MSB first, valid on rising sclk_i.
REQ-007 done_i  input  1  end-of-frame flag from the master; its rising edge closes a frame.
REQ-008 rd_en_i  input  1  pop request for the head word.
REQ-009 rd_data_o  output  DATA_W  FIFO head word (first-word-fall-through).
REQ-010 empty_o  output  1  FIFO holds zero words.
REQ-011 full_o  output  1  FIFO holds DEPTH words.
REQ-012 count_o  output  $clog2(DEPTH)+1  number of stored words.
REQ-013 frame_err_o  output  1  one-cycle pulse: frame closed with a partial word.
REQ-014 overflow_o  output  1  sticky: a completed word was dropped because the FIFO was full.

Function
REQ-015 sclk_i, mosi_i and done_i SHALL each pass through a 2-flop synchronizer, plus a third flop on sclk_i and done_i for edge detection.
REQ-016 An sclk edge cycle SHALL be the clk cycle in which synchronized sclk is 1 and its delayed copy is 0; mosi is sampled from its synchronizer in that cycle.
REQ-017 Correct operation SHALL be guaranteed for sclk_i high and low phases each >= 2 clk periods.
REQ-018 FSM states SHALL be IDLE, SHIFT and COMMIT.
REQ-019 IDLE: bit counter is 0; an sclk edge shifts in bit 1 and moves to SHIFT (or to COMMIT when DATA_W is reached).
REQ-020 SHIFT: each sclk edge shifts left, inserting mosi at the LSB, and increments the bit counter.
REQ-021 The edge that makes the bit count equal DATA_W SHALL move the FSM to COMMIT.
REQ-022 COMMIT SHALL last exactly one cycle: push the word, clear the bit counter, return to IDLE.
REQ-023 An sclk edge arriving during COMMIT SHALL be captured as bit 1 of the next word (no bit lost).
REQ-024 A done rising edge in SHIFT SHALL discard the partial word, pulse frame_err_o for one cycle, and return to IDLE; in IDLE or COMMIT it has no effect.
REQ-025 The pushed word SHALL become visible with empty_o low and count_o updated one cycle after COMMIT.
REQ-026 Push when not full: the word is stored and count_o increments.
REQ-027 Push when full without rd_en_i: the word is dropped, overflow_o is set, and the stored words are unchanged.
REQ-028 Push when full with rd_en_i in the same cycle: both the pop and the push succeed, count_o stays DEPTH, and overflow_o is unchanged.
REQ-029 Pop when empty: ignored, with no pointer or count change.
REQ-030 Simultaneous push and pop when not empty: count_o is unchanged.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH.
REQ-032 full_o and empty_o SHALL be derived from count_o and never both be asserted.

Reset
REQ-033 When rst is high at a clk edge, all of the following SHALL hold on the next cycle:
  - FSM in IDLE, bit counter 0, shift register 0;
  - pointers 0, count_o 0, empty_o 1, full_o 0;
  - rd_data_o 0, frame_err_o 0, overflow_o 0;
  - synchronizer flops 0.
REQ-034 A reset mid-frame SHALL discard the partial word with no frame_err_o pulse.
REQ-035 overflow_o SHALL be cleared only by rst.

Verification
REQ-036 Scenario 1: send 0xA5C3 as 16 MSB-first bits at sclk = clk/8, then pulse done_i.
  - rd_data_o = 0xA5C3, count_o = 1, empty_o = 0;
  - no frame_err_o pulse.
REQ-037 Scenario 2: send 9 words 0x0001..0x0009 with no reads.
  - after word 8: full_o = 1;
  - after word 9: overflow_o = 1, count_o = 8;
  - eight pops return 0x0001..0x0008, then empty_o = 1.
REQ-038 Scenario 3: send 5 bits then a done_i rising edge.
  - frame_err_o is high for exactly 1 cycle, count_o is unchanged;
  - the next full word 0x1234 is received intact.
REQ-039 Scenario 4: FIFO full, hold rd_en_i = 1 in the COMMIT+1 cycle of word 0xBEEF.
  - count_o = 8, overflow_o = 0;
  - 0xBEEF is the last word popped.
REQ-040 Scenario 5: assert rst after 10 bits of a frame.
  - all reset values hold, with no frame_err_o pulse;
  - the next word 0x00FF is received correctly.
REQ-041 Scenario 6: fill and drain the FIFO 3 times with DEPTH = 8.
  - data order is preserved across pointer wrap-around;
  - pops while empty_o = 1 leave count_o at 0.
